// File: rtl/johnson_ring_decoder.sv
// Decodes ring/Johnson counter words, tracks sequence lock and counts violations.
// Latency: one cycle from sampled code to registered outputs.
// Backpressure: none; a sample is taken on every in_valid cycle, and idle cycles hold state.
module johnson_ring_decoder #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [3:0]       code,
    output logic             out_valid,
    output logic [2:0]       index,
    output logic             legal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        CHECK    = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] ref_q;
    logic       mode_q;

    logic       dec_legal;
    logic [2:0] dec_index;
    logic [3:0] succ;
    logic       in_seq;
    logic       viol;

    always_comb begin
        dec_legal = 1'b0;
        dec_index = 3'd0;
        if (mode) begin
            case (code)
                4'b0000: begin dec_legal = 1'b1; dec_index = 3'd0; end
                4'b0001: begin dec_legal = 1'b1; dec_index = 3'd1; end
                4'b0011: begin dec_legal = 1'b1; dec_index = 3'd2; end
                4'b0111: begin dec_legal = 1'b1; dec_index = 3'd3; end
                4'b1111: begin dec_legal = 1'b1; dec_index = 3'd4; end
                4'b1110: begin dec_legal = 1'b1; dec_index = 3'd5; end
                4'b1100: begin dec_legal = 1'b1; dec_index = 3'd6; end
                4'b1000: begin dec_legal = 1'b1; dec_index = 3'd7; end
                default: begin dec_legal = 1'b0; dec_index = 3'd0; end
            endcase
        end else begin
            case (code)
                4'b0001: begin dec_legal = 1'b1; dec_index = 3'd0; end
                4'b0010: begin dec_legal = 1'b1; dec_index = 3'd1; end
                4'b0100: begin dec_legal = 1'b1; dec_index = 3'd2; end
                4'b1000: begin dec_legal = 1'b1; dec_index = 3'd3; end
                default: begin dec_legal = 1'b0; dec_index = 3'd0; end
            endcase
        end
    end

    // Successor of the stored word in the stored mode; the Johnson twist inverts the fed-back MSB.
    assign succ   = mode_q ? {ref_q[2:0], ~ref_q[3]} : {ref_q[2:0], ref_q[3]};
    assign in_seq = (code == succ);

    always_comb begin
        state_d = state_q;
        viol    = 1'b0;
        if (in_valid) begin
            if (mode != mode_q) begin
                state_d = dec_legal ? CHECK : UNLOCKED;
            end else begin
                case (state_q)
                    UNLOCKED: state_d = dec_legal ? CHECK : UNLOCKED;
                    CHECK: begin
                        if (in_seq) state_d = LOCKED;
                        else        state_d = dec_legal ? CHECK : UNLOCKED;
                    end
                    LOCKED: begin
                        if (in_seq) begin
                            state_d = LOCKED;
                        end else begin
                            viol    = 1'b1;
                            state_d = dec_legal ? CHECK : UNLOCKED;
                        end
                    end
                    default: state_d = UNLOCKED;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= UNLOCKED;
            ref_q     <= 4'b0000;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            index     <= 3'd0;
            legal     <= 1'b0;
            seq_err   <= 1'b0;
            locked    <= 1'b0;
            err_count <= '0;
        end else begin
            state_q   <= state_d;
            out_valid <= in_valid;
            if (in_valid) begin
                ref_q   <= code;
                mode_q  <= mode;
                index   <= dec_index;
                legal   <= dec_legal;
                seq_err <= viol;
                locked  <= (state_d == LOCKED);
                if (viol && !(&err_count)) begin
                    err_count <= err_count + 1'b1;
                end
            end else begin
                seq_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_johnson_ring_decoder.sv
// Randomised plus directed bench for johnson_ring_decoder with a queue scoreboard.
// Latency: expected items are consumed one cycle after the sample is driven.
// Backpressure: none; the monitor also checks held outputs on idle cycles.
module tb_johnson_ring_decoder;

    localparam int EW      = 2;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          mode;
    logic [3:0]    code;
    logic          out_valid;
    logic [2:0]    index;
    logic          legal;
    logic          seq_err;
    logic          locked;
    logic [EW-1:0] err_count;

    johnson_ring_decoder #(.ERR_W(EW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .code      (code),
        .out_valid (out_valid),
        .index     (index),
        .legal     (legal),
        .seq_err   (seq_err),
        .locked    (locked),
        .err_count (err_count)
    );

    typedef struct packed {
        logic [2:0]    index;
        logic          legal;
        logic          seq_err;
        logic          locked;
        logic [EW-1:0] err;
    } exp_t;

    exp_t q[$];
    exp_t held;
    int   total;
    int   bad;
    int   pulses;

    logic [3:0] ring_l[4];
    logic [3:0] john_l[8];

    // Reference model: position in the ordered code list, previous position, lock flag.
    int m_prev_pos;
    bit m_locked;
    bit m_mode;
    int m_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int seq_len(input bit md);
        return md ? 8 : 4;
    endfunction

    function automatic int pos_of(input bit md, input logic [3:0] c);
        for (int i = 0; i < seq_len(md); i++) begin
            if ((md ? john_l[i] : ring_l[i]) == c) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] code_at(input bit md, input int p);
        return md ? john_l[p] : ring_l[p];
    endfunction

    task automatic model_reset();
        m_prev_pos = -1;
        m_locked   = 1'b0;
        m_mode     = 1'b0;
        m_err      = 0;
    endtask

    task automatic model_step(input bit md, input logic [3:0] c, output exp_t e);
        int p;
        bit err;
        bit follows;
        p       = pos_of(md, c);
        err     = 1'b0;
        follows = (m_prev_pos >= 0) && (p >= 0) && (p == (m_prev_pos + 1) % seq_len(md));
        if (md != m_mode) begin
            m_locked = 1'b0;
        end else if (m_locked) begin
            if (!follows) begin
                err      = 1'b1;
                m_locked = 1'b0;
            end
        end else if (follows) begin
            m_locked = 1'b1;
        end
        if (err && m_err < ERR_MAX) m_err++;
        m_prev_pos = p;
        m_mode     = md;
        e.index    = (p >= 0) ? 3'(p) : 3'd0;
        e.legal    = (p >= 0);
        e.seq_err  = err;
        e.locked   = m_locked;
        e.err      = EW'(m_err);
    endtask

    task automatic send(input bit md, input logic [3:0] c);
        exp_t e;
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        mode     = md;
        code     = c;
        model_step(md, c, e);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            in_valid = 1'b0;
            code     = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic do_reset();
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_async_outputs",
            int'({out_valid, index, legal, seq_err, locked, err_count}), 0);
        q.delete();
        model_reset();
        held = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("outputs", int'({index, legal, seq_err, locked, err_count}), int'(e));
                    held = e;
                    if (seq_err) pulses++;
                end
            end else begin
                chk("idle_seq_err", int'(seq_err), 0);
                chk("idle_hold", int'({index, legal, locked, err_count}),
                    int'({held.index, held.legal, held.locked, held.err}));
            end
        end
    end

    initial begin
        logic [3:0] c;
        bit         md;
        total    = 0;
        bad      = 0;
        pulses   = 0;
        held     = '0;
        ring_l   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        john_l   = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                     4'b1111, 4'b1110, 4'b1100, 4'b1000};
        rst_n    = 1'b0;
        in_valid = 1'b0;
        mode     = 1'b0;
        code     = 4'b0000;
        model_reset();
        #1;
        chk("reset_state",
            int'({out_valid, index, legal, seq_err, locked, err_count}), 0);
        #20;
        rst_n = 1'b1;

        // Ring lock with wrap-around.
        foreach (ring_l[i]) send(1'b0, ring_l[i]);
        send(1'b0, 4'b0001);
        idle(2);

        // Johnson full cycle from a fresh start.
        do_reset();
        foreach (john_l[i]) send(1'b1, john_l[i]);
        send(1'b1, 4'b0000);
        idle(2);

        // Johnson skip from 0011 to 1111, then resume.
        do_reset();
        send(1'b1, 4'b0000); send(1'b1, 4'b0001); send(1'b1, 4'b0011);
        send(1'b1, 4'b1111); send(1'b1, 4'b1110);
        idle(2);

        // Illegal code while ring locked, then relock.
        do_reset();
        send(1'b0, 4'b0001); send(1'b0, 4'b0010); send(1'b0, 4'b0110);
        send(1'b0, 4'b0001); send(1'b0, 4'b0010);
        idle(2);

        // Gap while locked, resume, then mode flip.
        send(1'b0, 4'b0100); send(1'b0, 4'b1000);
        idle(3);
        send(1'b0, 4'b0001);
        send(1'b1, 4'b0001);
        send(1'b1, 4'b0011);
        idle(2);

        // Five violations saturate a 2-bit counter.
        do_reset();
        pulses = 0;
        foreach (ring_l[i]) begin
            send(1'b0, ring_l[i]);
            if (i > 0) send(1'b0, ring_l[i]);
        end
        send(1'b0, 4'b0001); send(1'b0, 4'b0001);
        send(1'b0, 4'b0010); send(1'b0, 4'b0010);
        idle(3);
        chk("sat_pulses", pulses, 5);
        chk("sat_count", int'(err_count), 3);

        // Mid-stream reset discards the in-flight sample.
        send(1'b0, 4'b0100); send(1'b0, 4'b1000);
        do_reset();
        send(1'b1, 4'b0111);
        idle(2);

        // Random traffic biased toward in-sequence codes.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            if ($urandom_range(0, 9) < 2) begin
                idle(1);
            end else begin
                md = ($urandom_range(0, 19) == 0) ? ~m_mode : m_mode;
                if (m_prev_pos >= 0 && md == m_mode && $urandom_range(0, 9) < 7)
                    c = code_at(md, (m_prev_pos + 1) % seq_len(md));
                else if ($urandom_range(0, 1) == 0)
                    c = code_at(md, $urandom_range(0, seq_len(md) - 1));
                else
                    c = 4'($urandom_range(0, 15));
                send(md, c);
            end
        end
        idle(4);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/johnson_ring_decoder.md
JOHNSON_RING_DECODER -- requirements
Module: johnson_ring_decoder

Interface
REQ-001 SHALL have parameter ERR_W, default 8: width of the saturating error counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the posedge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: code and mode are sampled this cycle.
REQ-005 SHALL have port mode, input, 1: 0 = ring (one-hot rotate-left), 1 = Johnson (twisted-ring shift-left).
REQ-006 SHALL have port code, input, 4: counter word to decode.
REQ-007 SHALL have port out_valid, output, 1: registered copy of in_valid.
REQ-008 SHALL have port index, output, 3: decoded position.
REQ-009 SHALL have port legal, output, 1: the sampled code is a member of the selected code set.
REQ-010 SHALL have port seq_err, output, 1: one-cycle pulse on a sequence violation while LOCKED.
REQ-011 SHALL have port locked, output, 1: high when the FSM is in LOCKED.
REQ-012 SHALL have port err_count, output, ERR_W: saturating count of seq_err pulses.

Function
REQ-013 SHALL register all outputs with 1-cycle latency: a code sampled at edge N appears on the outputs after edge N.
REQ-014 SHALL decode ring mode as 0001->0, 0010->1, 0100->2, 1000->3; all other codes SHALL give legal=0 and index=0.
REQ-015 SHALL decode Johnson mode as 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7; the other 8 codes SHALL give legal=0 and index=0.
REQ-016 SHALL define the expected successor as follows:
- ring mode: {c[2:0], c[3]}.
- Johnson mode: {c[2:0], ~c[3]}.
- wrap-around: 1000->0001 (ring) and 1000->0000 (Johnson) are in sequence.
REQ-017 SHALL keep the last accepted code in a 4-bit ref register and the last accepted mode in a mode_q register.
REQ-018 SHALL implement a 3-state FSM with states UNLOCKED, CHECK and LOCKED; transitions occur only on cycles with in_valid=1.
REQ-019 SHALL, in UNLOCKED:
- legal code -> CHECK, ref<=code.
- illegal code -> stay in UNLOCKED.
REQ-020 SHALL, in CHECK:
- code == successor(ref) -> LOCKED.
- other legal code -> stay in CHECK.
- illegal code -> UNLOCKED.
- ref<=code in all three cases.
REQ-021 SHALL, in LOCKED:
- code == successor(ref) -> stay in LOCKED.
- otherwise -> pulse seq_err and increment err_count.
- after a violation, legal code -> CHECK, illegal code -> UNLOCKED.
- ref<=code in all cases.
REQ-022 SHALL treat a repeated code (code == ref) in LOCKED as a sequence violation.
REQ-023 SHALL, when in_valid=1 and mode != mode_q:
- force UNLOCKED, or CHECK if the code is legal in the new mode.
- load ref and mode_q.
- not assert seq_err.
REQ-024 SHALL, when in_valid=0: hold FSM, ref, mode_q, index, legal, locked and err_count, with out_valid=0 and seq_err=0.
REQ-025 SHALL saturate err_count at 2^ERR_W-1; a further violation SHALL still pulse seq_err.
REQ-026 SHALL drive locked=1 only in LOCKED; locked SHALL fall on the same output edge as seq_err.

Reset
REQ-027 SHALL, on rst_n=0, immediately and independently of clk, clear the outputs: out_valid=0, index=0, legal=0, seq_err=0, locked=0, err_count=0.
REQ-028 SHALL, on rst_n=0, immediately and independently of clk, clear internal state: FSM=UNLOCKED, ref=0000, mode_q=0.
REQ-029 SHALL, on reset assertion mid-stream, discard any in-flight sample; the first valid code after release is treated as coming from UNLOCKED.

Verification
REQ-030 Ring lock: mode=0, codes 0001,0010,0100,1000,0001 -> index 0,1,2,3,0; locked=1 from the 2nd output onward; seq_err=0.
REQ-031 Johnson full cycle: mode=1, eight codes 0000..1000 then 0000 -> index 0..7,0; locked=1 from the 2nd output onward; no seq_err.
REQ-032 Skip error: Johnson locked at 0011, then 1111 -> seq_err=1 for 1 cycle, err_count=1, locked=0, index=4, FSM=CHECK; next 1110 -> locked=1.
REQ-033 Illegal code: ring locked, then 0110 -> legal=0, index=0, seq_err=1, FSM=UNLOCKED; then 0001,0010 -> locked=1 after the 0010.
REQ-034 Gaps and mode switch: a locked stream with in_valid low for 3 cycles -> outputs held, out_valid=0, still locked on resume; a mode flip to 1 with 0001 -> CHECK, seq_err=0.
REQ-035 Saturation and reset: ERR_W=2 with 5 violations -> err_count=3 and 5 seq_err pulses; rst_n=0 mid-stream -> all outputs 0 without a clock edge.
